// File: rtl/git_clk_pkg.sv
// git_clk_pkg: shared constants and helpers for the git_clk_multi clock/step
// generator.
//   DEFAULT_HALF_100MHZ_1HZ : half-period giving a 1 Hz output from 100 MHz
//   STEP_INIT               : stepper phase pattern loaded at reset
//   sat_half()              : clamps a requested half-period to at least 1
package git_clk_pkg;

  localparam int unsigned DEFAULT_HALF_100MHZ_1HZ = 50_000_000;
  localparam logic [3:0]  STEP_INIT = 4'b0001;

  // Widest half-period counter supported by sat_half (CNT_W must not exceed it).
  localparam int SAT_W = 64;

  // A half-period of 0 would never reach its terminal count, so 0 runs as 1.
  function automatic logic [SAT_W-1:0] sat_half(input logic [SAT_W-1:0] half);
    return (half == '0) ? SAT_W'(1) : half;
  endfunction

endpackage

// File: rtl/git_clk_ch.sv
// git_clk_ch: one divided-clock channel of git_clk_multi.
// Counts 0..half_cur-1 and toggles clk_out at the terminal count. A new
// half-period written while running is parked in half_nxt and only takes
// effect at the next toggle, so the output never produces a runt phase.
// Optional feature macro: GIT_CLK_TICK_EN adds the tick output.
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   en               run enable; low holds the counter and output at 0
//   wr, wr_half      accepted config write and its raw half-period
//   pend             an update is waiting for the next boundary
//   clk_out          divided clock
//   tick             (GIT_CLK_TICK_EN) one-cycle pulse with each rising clk_out
module git_clk_ch
  import git_clk_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_100MHZ_1HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pend,
  output logic             clk_out
`ifdef GIT_CLK_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(sat_half(SAT_W'(DEFAULT_HALF)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_cur;
  logic [CNT_W-1:0] half_nxt;
  logic [CNT_W-1:0] wr_sat;
  logic             at_edge;

  assign wr_sat  = CNT_W'(sat_half(SAT_W'(wr_half)));
  assign at_edge = (cnt == half_cur - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      half_cur <= HALF_RST;
      pend     <= 1'b0;
    end else if (!en) begin
      // Disabled: park at the start of a low phase. Nothing is in flight,
      // so a parked or fresh update can land right away.
      cnt     <= '0;
      clk_out <= 1'b0;
      if (pend) begin
        half_cur <= half_nxt;
        pend     <= 1'b0;
      end else if (wr) begin
        half_cur <= wr_sat;
      end
    end else begin
      if (at_edge) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        if (pend) begin
          half_cur <= half_nxt;
          pend     <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // wr only arrives while pend is clear; a write on a toggle cycle
      // therefore waits for the following boundary.
      if (wr) begin
        pend <= 1'b1;
      end
    end
  end

  // Holding register for a deferred update; meaningful only while pend is set.
  always_ff @(posedge clk) begin
    if (wr && en) begin
      half_nxt <= wr_sat;
    end
  end

`ifdef GIT_CLK_TICK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
    end else begin
      tick <= en && at_edge && !clk_out;
    end
  end
`endif

endmodule

// File: rtl/git_clk_multi.sv
// git_clk_multi: multi-channel programmable clock divider plus a one-hot
// stepper phase sequencer on the PMOD JA header.
// Optional feature macro: GIT_CLK_TICK_EN adds the tick[NUM_CH] output.
// Ports:
//   clk        100 MHz system clock
//   reset      asynchronous active-low reset
//   cfg_valid  config write request
//   cfg_ready  write can be accepted for channel cfg_ch (combinational)
//   cfg_ch     target channel; values >= NUM_CH are accepted and dropped
//   cfg_half   new half-period in clk cycles (0 runs as 1)
//   ch_en      per-channel run enable
//   clk_out    divided clocks
//   ja         stepper phase pattern, advanced by rising edges of clk_out[0]
//   tick       (GIT_CLK_TICK_EN) one-cycle pulse with each rising clk_out[i]
module git_clk_multi
  import git_clk_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_100MHZ_1HZ,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [3:0]        ja
`ifdef GIT_CLK_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              clk0_q;

  // Decode by comparison rather than indexing so out-of-range channel
  // numbers fall through as "ready, write nothing".
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) begin
        cfg_ready = !pend[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_valid && cfg_ready && (32'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    git_clk_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[g]),
      .wr      (wr[g]),
      .wr_half (cfg_half),
      .pend    (pend[g]),
      .clk_out (clk_out[g])
`ifdef GIT_CLK_TICK_EN
      ,
      .tick    (tick[g])
`endif
    );
  end

  // The step follows the registered rising edge of clk_out[0], so ja moves
  // one cycle after the channel output goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ja     <= STEP_INIT;
      clk0_q <= 1'b0;
    end else begin
      clk0_q <= clk_out[0];
      if (ch_en[0] && clk_out[0] && !clk0_q) begin
        ja <= {ja[2:0], ja[3]};
      end
    end
  end

endmodule
